sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter CFG_ADDR, default 21'h008FD5, the SRAM address of the persistent scandoubler settings byte.
REQ-002 SHALL have parameter BOOT_WAIT, default 3, the number of idle clk_sys cycles after reset before the boot read.
REQ-003 SHALL have port clk_sys, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports core_req (in, 1), core_we (in, 1), core_addr (in, 21) and core_dout (in, 8) for the core access request, write flag, address and write data.
REQ-006 SHALL have ports core_din (out, 8) and core_ack (out, 1) for core read data and a one-cycle completion pulse.
REQ-007 SHALL have ports cfg_wr_req (in, 1) and cfg_wr_data (in, 8) to request a settings write-back.
REQ-008 SHALL have ports cfg_wr_busy (out, 1), cfg_reg (out, 8) and cfg_valid (out, 1) for write-back pending, the loaded settings byte, and a boot-read-complete flag.
REQ-009 SHALL have ports SRAM_ADDR (out, 21), SRAM_WE (out, 1, high = write), SRAM_DATA_O (out, 8), SRAM_DATA_OE (out, 1) and SRAM_DATA_I (in, 8); the tristate buffer stays in the top level.

Function
REQ-010 SHALL use FSM states BOOT_WAIT, BOOT_RD, IDLE, CORE_A, CORE_D, CFG_A and CFG_D.
REQ-011 BOOT_WAIT SHALL count BOOT_WAIT cycles with SRAM_ADDR=CFG_ADDR and SRAM_WE=0, then go to BOOT_RD.
REQ-012 BOOT_RD SHALL latch SRAM_DATA_I into cfg_reg, set cfg_valid=1 on the next edge, and go to IDLE.
REQ-013 core_req SHALL be ignored while cfg_valid=0; a request held through boot is served after boot.
REQ-014 In IDLE, core_req=1 SHALL go to CORE_A, latching core_addr, core_we and core_dout.
REQ-015 In IDLE with no core_req and a pending write-back, the FSM SHALL go to CFG_A.
REQ-016 When both are pending in IDLE, core SHALL win, unless the previous grant was also core and the write-back was already pending, in which case CFG wins (no starvation).
REQ-017 CORE_A SHALL drive the latched address, with SRAM_WE=latched we and SRAM_DATA_OE=latched we.
REQ-018 CORE_D SHALL hold the same outputs, capture SRAM_DATA_I into core_din on reads, and pulse core_ack for exactly one cycle, two cycles after acceptance.
REQ-019 core_din SHALL hold its value until the next core read completes; core writes SHALL leave core_din unchanged.
REQ-020 CFG_A/CFG_D SHALL write the latched cfg_wr_data to CFG_ADDR over two cycles, and update cfg_reg to that value at the end of CFG_D.
REQ-021 A cfg_wr_req edge SHALL set cfg_wr_busy; it SHALL clear at the end of CFG_D; a new request while busy SHALL overwrite the latched data (last value wins).
REQ-022 In IDLE, SRAM_ADDR SHALL follow core_addr combinationally (zero-latency address for the core), with SRAM_WE=0 and SRAM_DATA_OE=0.
REQ-023 SRAM_WE SHALL never be 1 while SRAM_ADDR changes within an access.

Reset
REQ-024 Asserting reset SHALL asynchronously force state BOOT_WAIT, boot counter 0, cfg_reg=8'h00, cfg_valid=0, cfg_wr_busy=0, core_ack=0, core_din=0, SRAM_WE=0, SRAM_DATA_OE=0 and SRAM_ADDR=CFG_ADDR.
REQ-025 Reset mid-access SHALL abort the access without an ack, and the boot read SHALL repeat.

Configuration
REQ-026 With SRAM_CFG_WRITEBACK_EN defined, write-back SHALL behave per REQ-015, REQ-016, REQ-020 and REQ-021.
REQ-027 Without SRAM_CFG_WRITEBACK_EN, cfg_wr_req SHALL be ignored, cfg_wr_busy SHALL be tied to 0, and states CFG_A/CFG_D SHALL be absent.

Structure
REQ-028 Package ondra_sram_pkg SHALL hold the FSM state enum, the CFG_ADDR default and the address width constant 21.
REQ-029 No sub-module SHALL be used; the boot counter stays inline.

Verification
REQ-030 The bench SHALL cover: reset release with SRAM byte 8'h01 at 0x008FD5 -> cfg_valid=1 after BOOT_WAIT+2 cycles, cfg_reg=8'h01, SRAM_WE=0 throughout.
REQ-031 The bench SHALL cover: core read at 0x00100 holding 8'hA5 -> core_ack one cycle, two cycles after acceptance, core_din=8'hA5.
REQ-032 The bench SHALL cover: core write 8'h3C to 0x1FFFFF -> SRAM_WE=1 and OE=1 for 2 cycles at 0x1FFFFF, then ack.
REQ-033 The bench SHALL cover: cfg_wr_req(8'h00) with back-to-back core_req -> at most one core access, then a CFG write to 0x008FD5, cfg_reg=0, busy clears.
REQ-034 The bench SHALL cover: reset asserted during CORE_D -> no ack, outputs at reset values immediately, boot read repeats.
REQ-035 The bench SHALL cover: build without the macro with cfg_wr_req pulsed -> no SRAM write to CFG_ADDR and cfg_wr_busy stays 0.

Source files
------------

// File: rtl/ondra_sram_pkg.sv
// Shared definitions for the SRAM arbiter: address width, default location of
// the persistent scandoubler settings byte, and the arbiter FSM state encoding.
// The CFG_A/CFG_D states exist only when SRAM_CFG_WRITEBACK_EN is defined.
package ondra_sram_pkg;

    localparam int SRAM_AW = 21;
    localparam logic [SRAM_AW-1:0] CFG_ADDR_DEFAULT = 21'h008FD5;

    typedef enum logic [2:0] {
        ST_BOOT_WAIT = 3'd0,
        ST_BOOT_RD   = 3'd1,
        ST_IDLE      = 3'd2,
        ST_CORE_A    = 3'd3,
        ST_CORE_D    = 3'd4
`ifdef SRAM_CFG_WRITEBACK_EN
        ,
        ST_CFG_A     = 3'd5,
        ST_CFG_D     = 3'd6
`endif
    } arb_state_t;

endpackage

// File: rtl/sram_arbiter.sv
// SRAM arbiter: after reset it reads the settings byte at CFG_ADDR, then it
// serves two-cycle core accesses and (optionally) writes the settings byte back.
// Optional feature macro: SRAM_CFG_WRITEBACK_EN enables the settings write-back
// path (cfg_wr_req/cfg_wr_data, CFG_A/CFG_D states). Without it cfg_wr_busy is 0.
// The SRAM data tristate buffer lives in the enclosing top level.
module sram_arbiter
    import ondra_sram_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] CFG_ADDR  = CFG_ADDR_DEFAULT,
    parameter int                 BOOT_WAIT = 3
) (
    input  logic               clk_sys,
    input  logic               reset,

    input  logic               core_req,
    input  logic               core_we,
    input  logic [SRAM_AW-1:0] core_addr,
    input  logic [7:0]         core_dout,
    output logic [7:0]         core_din,
    output logic               core_ack,

    input  logic               cfg_wr_req,
    input  logic [7:0]         cfg_wr_data,
    output logic               cfg_wr_busy,
    output logic [7:0]         cfg_reg,
    output logic               cfg_valid,

    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE,
    output logic [7:0]         SRAM_DATA_O,
    output logic               SRAM_DATA_OE,
    input  logic [7:0]         SRAM_DATA_I
);

    // The boot counter has to reach BOOT_WAIT itself, so it needs one spare code.
    localparam int               CNT_W     = $clog2(BOOT_WAIT + 2);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_WAIT);

    arb_state_t         state;
    arb_state_t         state_nx;
    logic [CNT_W-1:0]   boot_cnt;

    logic [SRAM_AW-1:0] lat_addr;
    logic               lat_we;
    logic [7:0]         lat_wdata;

`ifdef SRAM_CFG_WRITEBACK_EN
    logic               cfg_busy;
    logic               cfg_req_q;
    logic [7:0]         cfg_data;
    logic               last_core;
    logic               cfg_edge;

    assign cfg_edge    = cfg_wr_req && !cfg_req_q;
    assign cfg_wr_busy = cfg_busy;
`else
    logic               unused_cfg;

    assign unused_cfg  = ^{cfg_wr_req, cfg_wr_data};
    assign cfg_wr_busy = 1'b0;
`endif

    // State register; any reset restarts from the boot wait, aborting an access
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT_WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection and SRAM pin drive; idle passes the core address straight through
    always_comb begin
        state_nx     = state;
        SRAM_ADDR    = CFG_ADDR;
        SRAM_WE      = 1'b0;
        SRAM_DATA_O  = 8'h00;
        SRAM_DATA_OE = 1'b0;
        case (state)
            ST_BOOT_WAIT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_nx = ST_BOOT_RD;
                end
            end
            ST_BOOT_RD: begin
                state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                SRAM_ADDR = core_addr;
`ifdef SRAM_CFG_WRITEBACK_EN
                // A pending write-back yields to the core at most once in a row.
                if (cfg_busy && (!core_req || last_core)) begin
                    state_nx = ST_CFG_A;
                end else if (core_req && cfg_valid) begin
                    state_nx = ST_CORE_A;
                end
`else
                if (core_req && cfg_valid) begin
                    state_nx = ST_CORE_A;
                end
`endif
            end
            ST_CORE_A, ST_CORE_D: begin
                // Address and WE come from the latched request, so neither moves mid-access.
                SRAM_ADDR    = lat_addr;
                SRAM_WE      = lat_we;
                SRAM_DATA_OE = lat_we;
                SRAM_DATA_O  = lat_wdata;
                state_nx     = (state == ST_CORE_A) ? ST_CORE_D : ST_IDLE;
            end
`ifdef SRAM_CFG_WRITEBACK_EN
            ST_CFG_A, ST_CFG_D: begin
                SRAM_WE      = 1'b1;
                SRAM_DATA_OE = 1'b1;
                SRAM_DATA_O  = cfg_data;
                state_nx     = (state == ST_CFG_A) ? ST_CFG_D : ST_IDLE;
            end
`endif
            default: begin
                state_nx = ST_BOOT_WAIT;
            end
        endcase
    end

    // Boot counter, settings byte, core read data and the completion pulse
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            boot_cnt  <= '0;
            cfg_reg   <= 8'h00;
            cfg_valid <= 1'b0;
            core_ack  <= 1'b0;
            core_din  <= 8'h00;
        end else begin
            core_ack <= (state == ST_CORE_D);
            if (state == ST_BOOT_WAIT && boot_cnt != BOOT_LAST) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
            if (state == ST_BOOT_RD) begin
                cfg_reg   <= SRAM_DATA_I;
                cfg_valid <= 1'b1;
            end
`ifdef SRAM_CFG_WRITEBACK_EN
            if (state == ST_CFG_D) begin
                cfg_reg <= cfg_data;
            end
`endif
            if (state == ST_CORE_D && !lat_we) begin
                core_din <= SRAM_DATA_I;
            end
        end
    end

    // Capture the core request on acceptance; it stays fixed for the whole access
    always_ff @(posedge clk_sys) begin
        if (state == ST_IDLE && state_nx == ST_CORE_A) begin
            lat_addr  <= core_addr;
            lat_we    <= core_we;
            lat_wdata <= core_dout;
        end
    end

`ifdef SRAM_CFG_WRITEBACK_EN
    // Write-back request tracking and the last-grant flag used for fairness
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cfg_req_q <= 1'b0;
            cfg_busy  <= 1'b0;
            last_core <= 1'b0;
        end else begin
            cfg_req_q <= cfg_wr_req;
            // A fresh request landing on the final write cycle keeps busy set so it is written too.
            if (cfg_edge) begin
                cfg_busy <= 1'b1;
            end else if (state == ST_CFG_D) begin
                cfg_busy <= 1'b0;
            end
            if (state == ST_IDLE && state_nx == ST_CORE_A) begin
                last_core <= 1'b1;
            end else if (state == ST_IDLE && state_nx == ST_CFG_A) begin
                last_core <= 1'b0;
            end
        end
    end

    // Write-back data; a newer request overwrites an older pending one
    always_ff @(posedge clk_sys) begin
        if (cfg_edge) begin
            cfg_data <= cfg_wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM and an ack scoreboard.
// Covers the write-back path when SRAM_CFG_WRITEBACK_EN is defined, and the
// ignored cfg_wr_req otherwise.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam logic [20:0] CFG_AD = 21'h008FD5;
    localparam int          BW     = 3;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [20:0] core_addr;
    logic [7:0]  core_dout;
    logic [7:0]  core_din;
    logic        core_ack;
    logic        cfg_wr_req;
    logic [7:0]  cfg_wr_data;
    logic        cfg_wr_busy;
    logic [7:0]  cfg_reg;
    logic        cfg_valid;
    logic [20:0] SRAM_ADDR;
    logic        SRAM_WE;
    logic [7:0]  SRAM_DATA_O;
    logic        SRAM_DATA_OE;
    logic [7:0]  SRAM_DATA_I = 8'h00;

    always #5 clk_sys = ~clk_sys;

    sram_arbiter #(.CFG_ADDR(CFG_AD), .BOOT_WAIT(BW)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .core_req     (core_req),
        .core_we      (core_we),
        .core_addr    (core_addr),
        .core_dout    (core_dout),
        .core_din     (core_din),
        .core_ack     (core_ack),
        .cfg_wr_req   (cfg_wr_req),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_wr_busy  (cfg_wr_busy),
        .cfg_reg      (cfg_reg),
        .cfg_valid    (cfg_valid),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_WE      (SRAM_WE),
        .SRAM_DATA_O  (SRAM_DATA_O),
        .SRAM_DATA_OE (SRAM_DATA_OE),
        .SRAM_DATA_I  (SRAM_DATA_I)
    );

    typedef struct packed {
        logic        we;
        logic [20:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [logic [20:0]];
    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] last_rd  = 8'h00;

    // Initial SRAM contents: settings byte 01, A5 at 0x00100, FF elsewhere
    function automatic logic [7:0] rd(input logic [20:0] a);
        if (mem.exists(a)) return mem[a];
        if (a == CFG_AD) return 8'h01;
        if (a == 21'h00100) return 8'hA5;
        return 8'hFF;
    endfunction

    function automatic exp_t mk(input logic w, input logic [20:0] a, input logic [7:0] d);
        exp_t e;
        e.we = w;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model: commit writes and present read data in the middle of each cycle
    always @(negedge clk_sys) begin
        if (SRAM_WE === 1'b1 && SRAM_DATA_OE === 1'b1) mem[SRAM_ADDR] = SRAM_DATA_O;
        SRAM_DATA_I = rd(SRAM_ADDR);
    end

    // Scoreboard: each ack consumes the oldest expected core access
    always @(negedge clk_sys) begin
        exp_t e;
        if (reset) begin
            last_rd = 8'h00;
        end else if (core_ack) begin
            chk("ack_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.we) begin
                    chk("wr_mem", rd(e.addr), e.data);
                    chk("wr_din_hold", core_din, last_rd);
                end else begin
                    chk("rd_din", core_din, e.data);
                    last_rd = e.data;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic boot_check(input logic [7:0] exp_cfg);
        for (int k = 1; k <= BW + 2; k++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            chk("boot_we", SRAM_WE, 1'b0);
            chk("boot_ack", core_ack, 1'b0);
            if (k <= BW + 1) chk("boot_addr", SRAM_ADDR, CFG_AD);
            chk("boot_valid", cfg_valid, k == BW + 2);
        end
        chk("boot_cfg", cfg_reg, exp_cfg);
    endtask

    task automatic core_access(input logic [20:0] a, input logic w, input logic [7:0] d,
                               input logic [7:0] exp_rd);
        @(posedge clk_sys); #1;
        core_req  = 1'b1;
        core_addr = a;
        core_we   = w;
        core_dout = d;
        exp_q.push_back(mk(w, a, w ? d : exp_rd));
        @(posedge clk_sys); #1;
        core_req  = 1'b0;
        core_addr = ~a;
        for (int c = 0; c < 2; c++) begin
            if (c != 0) @(posedge clk_sys);
            @(negedge clk_sys);
            chk("acc_addr", SRAM_ADDR, a);
            chk("acc_we", SRAM_WE, w);
            chk("acc_oe", SRAM_DATA_OE, w);
            if (w) chk("acc_wdata", SRAM_DATA_O, d);
            chk("acc_ack_early", core_ack, 1'b0);
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("acc_ack", core_ack, 1'b1);
        chk("acc_idle_we", SRAM_WE, 1'b0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("acc_ack_one", core_ack, 1'b0);
    endtask

    initial begin
        int         seen;
        int         wb_cyc;
        logic [7:0] exp_cfg;
`ifdef SRAM_CFG_WRITEBACK_EN
        int         n_ack;
        int         acks_pre;
`endif
        reset = 1'b1;
        core_req = 1'b0;
        core_we = 1'b0;
        core_addr = 21'h0;
        core_dout = 8'h00;
        cfg_wr_req = 1'b0;
        cfg_wr_data = 8'h00;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_addr", SRAM_ADDR, CFG_AD);
        chk("rst_we", SRAM_WE, 1'b0);
        chk("rst_oe", SRAM_DATA_OE, 1'b0);
        chk("rst_valid", cfg_valid, 1'b0);
        chk("rst_cfg", cfg_reg, 8'h00);
        chk("rst_ack", core_ack, 1'b0);
        chk("rst_din", core_din, 8'h00);
        chk("rst_busy", cfg_wr_busy, 1'b0);

        @(posedge clk_sys); #1;
        reset = 1'b0;
        boot_check(8'h01);

        core_access(21'h00100, 1'b0, 8'h00, 8'hA5);
        core_access(21'h1FFFFF, 1'b1, 8'h3C, 8'h00);
        core_access(21'h1FFFFF, 1'b0, 8'h00, 8'h3C);

        core_addr = 21'h0ABCDE;
        #1;
        chk("idle_addr", SRAM_ADDR, 21'h0ABCDE);
        chk("idle_we", SRAM_WE, 1'b0);
        chk("idle_oe", SRAM_DATA_OE, 1'b0);

`ifdef SRAM_CFG_WRITEBACK_EN
        @(posedge clk_sys); #1;
        core_req = 1'b1;
        core_we = 1'b0;
        core_addr = 21'h00100;
        cfg_wr_data = 8'h00;
        cfg_wr_req = 1'b1;
        exp_q.push_back(mk(1'b0, 21'h00100, 8'hA5));
        @(posedge clk_sys); #1;
        cfg_wr_req = 1'b0;
        @(negedge clk_sys);
        chk("wb_busy_set", cfg_wr_busy, 1'b1);
        n_ack = 0;
        acks_pre = -1;
        wb_cyc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_sys);
            if (core_ack) n_ack++;
            if (SRAM_WE && SRAM_ADDR == CFG_AD) begin
                if (wb_cyc == 0) acks_pre = n_ack;
                wb_cyc++;
                chk("wb_data", SRAM_DATA_O, 8'h00);
                core_req = 1'b0;
            end
        end
        chk("wb_core_before", acks_pre, 1);
        chk("wb_cycles", wb_cyc, 2);
        chk("wb_total_acks", n_ack, 1);
        chk("wb_mem", rd(CFG_AD), 8'h00);
        chk("wb_cfg_reg", cfg_reg, 8'h00);
        chk("wb_busy_clr", cfg_wr_busy, 1'b0);
        exp_cfg = 8'h00;
`else
        @(posedge clk_sys); #1;
        cfg_wr_data = 8'h5A;
        cfg_wr_req = 1'b1;
        @(posedge clk_sys); #1;
        cfg_wr_req = 1'b0;
        wb_cyc = 0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_sys);
            if (SRAM_WE && SRAM_ADDR == CFG_AD) wb_cyc++;
            if (cfg_wr_busy !== 1'b0) seen++;
        end
        chk("nowb_cfg_writes", wb_cyc, 0);
        chk("nowb_busy", seen, 0);
        chk("nowb_cfg_reg", cfg_reg, 8'h01);
        chk("nowb_mem", rd(CFG_AD), 8'h01);
        exp_cfg = 8'h01;
`endif

        @(posedge clk_sys); #1;
        core_req = 1'b1;
        core_we = 1'b0;
        core_addr = 21'h00100;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        reset = 1'b1;
        #1;
        chk("abort_addr", SRAM_ADDR, CFG_AD);
        chk("abort_we", SRAM_WE, 1'b0);
        chk("abort_oe", SRAM_DATA_OE, 1'b0);
        chk("abort_ack", core_ack, 1'b0);
        chk("abort_valid", cfg_valid, 1'b0);
        chk("abort_cfg", cfg_reg, 8'h00);
        chk("abort_din", core_din, 8'h00);
        chk("abort_busy", cfg_wr_busy, 1'b0);
        @(posedge clk_sys);
        @(posedge clk_sys); #1;
        chk("abort_noack", core_ack, 1'b0);
        exp_q.push_back(mk(1'b0, 21'h00100, 8'hA5));
        reset = 1'b0;
        boot_check(exp_cfg);
        @(posedge clk_sys); #1;
        core_req = 1'b0;
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            @(negedge clk_sys);
            if (core_ack) seen = 1;
        end
        chk("held_req_ack", seen, 1);

        repeat (3) @(negedge clk_sys);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
